count_bcd_scan: RTL
===================

Name: count_bcd_scan

Overview:
Downstream consumer of the up/down counter stage. Accepts a binary count over a valid/ready handshake and converts it to packed BCD with a sequential double-dabble (one bit per cycle). It then drives a multiplexed, one-hot-scanned 7-segment display from the last completed result. The held display register means a conversion in progress never tears the visible digits.

Parameters:
WIDTH, 16, bit width of in_count; DIGITS must satisfy DIGITS >= ceil(WIDTH*log10(2)).
DIGITS, 5, number of BCD digits and display digits.
SCAN_DIV, 1000, clk cycles each digit stays selected (>=1).
BLANK, 1, 1 = leading-zero blanking enabled; digit 0 is never blanked.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  upstream count valid
in_ready  out  1  block can accept a count
in_count  in  WIDTH  binary count to convert
bcd_out  out  4*DIGITS  last completed result; digit 0 in [3:0]
bcd_valid  out  1  one-cycle pulse when bcd_out updates
dig_sel  out  DIGITS  one-hot digit enable, active-high
seg_out  out  7  {g,f,e,d,c,b,a}, active-high

Behaviour:
- Reset (async, active-high): FSM=IDLE; bcd_out=0; bcd_valid=0; scan index=0; scan divider=0; dig_sel=1; seg_out=7'b0111111 ("0"); in_ready=1.
- FSM IDLE:
  - in_ready=1.
  - On a clock edge with in_valid&&in_ready: capture in_count into the shift register, clear the BCD scratch, load iteration counter=WIDTH, go to CONV.
- FSM CONV:
  - in_ready=0; in_valid is ignored, and upstream must hold its value.
  - Each cycle: every scratch nibble >=5 gets +3, then {scratch,shift} shifts left 1; the iteration counter decrements.
  - On the final iteration: bcd_out takes the scratch result, bcd_valid=1 for the next cycle, FSM goes to IDLE.
- Latency: handshake at edge 0; bcd_out and bcd_valid update at edge WIDTH; in_ready is low exactly WIDTH cycles. A new handshake is allowed in the same cycle bcd_valid is high.
- Scratch arithmetic is nibble-wise; no carry between nibbles ever exceeds 9 given the DIGITS constraint; no overflow output.
- Scan:
  - Divider counts 0..SCAN_DIV-1 and wraps.
  - On wrap, the index advances 0..DIGITS-1 and wraps to 0.
  - dig_sel = 1<<index.
  - seg_out = decode of bcd_out nibble[index], registered with dig_sel (same cycle alignment).
- Blanking (BLANK=1): digit i>0 shows 7'b0000000 if it and all higher digits are 0.
- Nibble >9 (unreachable, defensive) shows dash 7'b1000000.
- Reset mid-conversion: aborts immediately; bcd_out cleared; no bcd_valid pulse.
- bcd_out only changes on conversion completion or reset.

Decomposition:
- Package count_disp_pkg:
  - FSM state enum {IDLE, CONV}.
  - Segment constants SEG_0..SEG_9, SEG_BLANK, SEG_DASH.
  - Function for ceil digit count check.
- One sub-module, seg7_decode: combinational 4-bit nibble -> 7-bit segments using the package constants; instantiated once after the digit mux.
- Double-dabble and scan logic stay in count_bcd_scan.

Test Plan:
- Reset: assert rst -> in_ready=1, bcd_out=0, bcd_valid=0, dig_sel=5'b00001, seg_out=7'b0111111.
- Handshake in_count=16'd12345 -> in_ready low 16 cycles; bcd_valid single pulse at edge 16; bcd_out=20'h12345.
- Boundaries: 16'd65535 -> 20'h65535; 16'd0 -> 20'h00000; back-to-back 9 then 10 (second valid held during first conversion) -> 20'h00009 then 20'h00010.
- Busy ignore: during conversion of 16'd7, toggle in_count=16'd999 with in_valid high -> result 20'h00007, then 999 accepted only after in_ready returns.
- Scan with SCAN_DIV=4, bcd_out=20'h00042, BLANK=1:
  - dig_sel steps 00001→00010→00100→01000→10000 every 4 clocks, back to 00001 after 20.
  - seg_out 1011011 ("2"), then 1100110 ("4"), then 0000000 for digits 2-4.
- Reset at CONV cycle 8 of 16'd500 -> bcd_out=0 immediately, no bcd_valid, in_ready=1; after release 16'd500 -> 20'h00500.

Source files
------------

// File: rtl/count_disp_pkg.sv
// Shared definitions for the BCD conversion and display-scan slice:
// FSM states, 7-segment glyphs and the digit-count sanity helper.
package count_disp_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CONV = 1'b1
   } state_e;

   // Segment order is {g,f,e,d,c,b,a}, active-high
   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;
   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_DASH  = 7'b1000000;

   // ceil(width * log10(2)) in integer arithmetic (log10(2) ~= 0.30103)
   function automatic int min_bcd_digits(input int width);
      return (width * 30103 + 99999) / 100000;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to 7-segment decoder; codes above 9 show a dash.
module seg7_decode
   import count_disp_pkg::*;
(
   input  logic [3:0] i_nibble,
   output logic [6:0] o_seg
);

   always_comb begin
      o_seg = SEG_DASH;
      case (i_nibble)
         4'd0:    o_seg = SEG_0;
         4'd1:    o_seg = SEG_1;
         4'd2:    o_seg = SEG_2;
         4'd3:    o_seg = SEG_3;
         4'd4:    o_seg = SEG_4;
         4'd5:    o_seg = SEG_5;
         4'd6:    o_seg = SEG_6;
         4'd7:    o_seg = SEG_7;
         4'd8:    o_seg = SEG_8;
         4'd9:    o_seg = SEG_9;
         default: o_seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/count_bcd_scan.sv
// Binary-to-BCD converter (sequential double-dabble) feeding a one-hot
// scanned 7-segment display that only ever shows completed results.
module count_bcd_scan
   import count_disp_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter int DIGITS   = 5,
   parameter int SCAN_DIV = 1000,
   parameter int BLANK    = 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [WIDTH-1:0]      in_count,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  bcd_valid,
   output logic [DIGITS-1:0]     dig_sel,
   output logic [6:0]            seg_out
);

   localparam int BW   = 4 * DIGITS;
   localparam int IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int DIVW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int ITW  = $clog2(WIDTH + 1);

   generate
      if (DIGITS < min_bcd_digits(WIDTH)) begin : g_digits_too_small
         $error("count_bcd_scan: DIGITS too small for WIDTH");
      end
   endgenerate

   state_e            r_state;
   logic [WIDTH-1:0]  r_shift;
   logic [BW-1:0]     r_scratch;
   logic [ITW-1:0]    r_iter;
   logic [BW-1:0]     r_bcd;
   logic              r_bcd_valid;

   logic [DIVW-1:0]   r_div;
   logic [IDXW-1:0]   r_idx;
   logic [DIGITS-1:0] r_dig_sel;
   logic [6:0]        r_seg;

   logic [BW-1:0]     w_adj;
   logic [BW-1:0]     w_scratch_next;
   logic [WIDTH-1:0]  w_shift_next;
   logic [DIGITS-1:0] w_lead_zero;
   logic              w_all_zero;
   logic [3:0]        w_nibble;
   logic              w_blank;
   logic [6:0]        w_seg_dec;
   logic [6:0]        w_seg_sel;

   assign in_ready  = (r_state == IDLE);
   assign bcd_out   = r_bcd;
   assign bcd_valid = r_bcd_valid;
   assign dig_sel   = r_dig_sel;
   assign seg_out   = r_seg;

   // Double-dabble correction: any nibble of 5 or more gets +3 so the
   // following left shift carries cleanly into the next decimal digit.
   always_comb begin
      w_adj = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (r_scratch[4*i +: 4] >= 4'd5)
            w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
         else
            w_adj[4*i +: 4] = r_scratch[4*i +: 4];
      end
   end

   assign {w_scratch_next, w_shift_next} = {w_adj, r_shift} << 1;

   // Conversion FSM: one shift per cycle, result lands in the held
   // display register only once all WIDTH bits have been consumed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_shift     <= '0;
         r_scratch   <= '0;
         r_iter      <= '0;
         r_bcd       <= '0;
         r_bcd_valid <= 1'b0;
      end else begin
         r_bcd_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  r_shift   <= in_count;
                  r_scratch <= '0;
                  r_iter    <= ITW'(WIDTH);
                  r_state   <= CONV;
               end
            end
            CONV: begin
               r_scratch <= w_scratch_next;
               r_shift   <= w_shift_next;
               r_iter    <= r_iter - 1'b1;
               if (r_iter == ITW'(1)) begin
                  r_bcd       <= w_scratch_next;
                  r_bcd_valid <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // w_lead_zero[i] is set when digit i and every digit above it are zero;
   // the selected digit's nibble and blank flag are muxed in the same pass.
   always_comb begin
      w_lead_zero = '0;
      w_all_zero  = 1'b1;
      w_nibble    = 4'd0;
      w_blank     = 1'b0;
      for (int i = DIGITS - 1; i >= 0; i--) begin
         w_all_zero     = w_all_zero && (r_bcd[4*i +: 4] == 4'd0);
         w_lead_zero[i] = w_all_zero;
      end
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == IDXW'(i)) begin
            w_nibble = r_bcd[4*i +: 4];
            w_blank  = (BLANK != 0) && (i != 0) && w_lead_zero[i];
         end
      end
   end

   seg7_decode u_seg7_decode (
      .i_nibble (w_nibble),
      .o_seg    (w_seg_dec)
   );

   assign w_seg_sel = w_blank ? SEG_BLANK : w_seg_dec;

   // Scan timing: digit enable and its segments are registered together
   // so the panel never shows one digit's glyph on its neighbour.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_div     <= '0;
         r_idx     <= '0;
         r_dig_sel <= DIGITS'(1);
         r_seg     <= SEG_0;
      end else begin
         if (r_div == DIVW'(SCAN_DIV - 1)) begin
            r_div <= '0;
            if (r_idx == IDXW'(DIGITS - 1))
               r_idx <= '0;
            else
               r_idx <= r_idx + 1'b1;
         end else begin
            r_div <= r_div + 1'b1;
         end
         r_dig_sel <= DIGITS'(1) << r_idx;
         r_seg     <= w_seg_sel;
      end
   end

endmodule
